// File: rtl/hex_keypad_scanner.sv
// 4x4 hex matrix keypad scanner: walks an active-low column, debounces a single active-low
// row, and shifts each accepted key code into a 16-bit entry register for a hex display.
module hex_keypad_scanner #(
    parameter int CNT_WIDTH      = 14,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_rows,
    input  logic        i_clear,
    output logic [3:0]  o_cols,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic [15:0] o_data,
    output logic        o_data_we
);

    localparam int            CW        = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [3:0]           rows_meta_r;
    logic [3:0]           rows_sync_r;
    logic [CNT_WIDTH-1:0] div_r;
    logic                 tick_s;
    state_t               state_r;
    state_t               state_s;
    logic [1:0]           col_r;
    logic [1:0]           col_s;
    logic [1:0]           row_r;
    logic [1:0]           row_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_s;
    logic [CW-1:0]        cnt_inc_s;
    logic                 press_valid_s;
    logic [1:0]           press_row_s;
    logic                 accept_s;
    logic [3:0]           code_s;

    // A press is exactly one low row; two or more low rows (ghosting) count as no press.
    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        case (rows)
            4'b1110: low_index = 2'd0;
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        case (col)
            2'd0:    col_drive = 4'b1110;
            2'd1:    col_drive = 4'b1101;
            2'd2:    col_drive = 4'b1011;
            2'd3:    col_drive = 4'b0111;
            default: col_drive = 4'b1110;
        endcase
    endfunction

    assign tick_s        = &div_r;
    assign press_valid_s = single_low(rows_sync_r);
    assign press_row_s   = low_index(rows_sync_r);
    assign cnt_inc_s     = (cnt_r == CNT_DONE) ? cnt_r : cnt_r + CNT_ONE;
    assign code_s        = {row_s, col_r};

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta_r <= 4'hF;
            rows_sync_r <= 4'hF;
        end else begin
            rows_meta_r <= i_rows;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Scan divider, FSM state, column, latched row and debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r   <= {CNT_WIDTH{1'b0}};
            state_r <= ST_SCAN;
            col_r   <= 2'd0;
            row_r   <= 2'd0;
            cnt_r   <= CNT_ZERO;
            o_cols  <= 4'b1110;
        end else begin
            div_r   <= div_r + CNT_WIDTH'(1);
            state_r <= state_s;
            col_r   <= col_s;
            row_r   <= row_s;
            cnt_r   <= cnt_s;
            o_cols  <= col_drive(col_s);
        end
    end

    // Next-state logic; the FSM only moves on scan ticks.
    always_comb begin
        state_s  = state_r;
        col_s    = col_r;
        row_s    = row_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (press_valid_s) begin
                        row_s = press_row_s;
                        if (DEBOUNCE_TICKS <= 1) begin
                            accept_s = 1'b1;
                            cnt_s    = CNT_ZERO;
                            state_s  = ST_HELD;
                        end else begin
                            cnt_s    = CNT_ONE;
                            state_s  = ST_DEBOUNCE;
                        end
                    end else begin
                        col_s = col_r + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (press_valid_s && (press_row_s == row_r)) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            accept_s = 1'b1;
                            cnt_s    = CNT_ZERO;
                            state_s  = ST_HELD;
                        end else begin
                            cnt_s    = cnt_inc_s;
                        end
                    end else begin
                        cnt_s   = CNT_ZERO;
                        col_s   = col_r + 2'd1;
                        state_s = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Release needs the same number of stable all-high samples as a press.
                    if (rows_sync_r == 4'hF) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            cnt_s   = CNT_ZERO;
                            col_s   = col_r + 2'd1;
                            state_s = ST_SCAN;
                        end else begin
                            cnt_s   = cnt_inc_s;
                        end
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                default: begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_SCAN;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Key output and entry register; clear wins over the shift but still keeps the new code.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_key       <= 4'h0;
            o_key_valid <= 1'b0;
            o_data      <= 16'h0000;
            o_data_we   <= 1'b0;
        end else begin
            o_key_valid <= accept_s;
            if (accept_s) begin
                o_key <= code_s;
            end else begin
                o_key <= o_key;
            end
            if (i_clear) begin
                o_data    <= accept_s ? {12'h000, code_s} : 16'h0000;
                o_data_we <= 1'b1;
            end else if (accept_s) begin
                o_data    <= {o_data[11:0], code_s};
                o_data_we <= 1'b1;
            end else begin
                o_data_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a small keypad model that pulls a row low
// while its column is driven.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic        i_clear;
    logic [3:0]  o_cols;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic [15:0] o_data;
    logic        o_data_we;

    logic        ka_en = 1'b0;
    logic [1:0]  ka_r = 2'd0;
    logic [1:0]  ka_c = 2'd0;
    logic        kb_en = 1'b0;
    logic [1:0]  kb_r = 2'd0;
    logic [1:0]  kb_c = 2'd0;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int we_cnt = 0;
    int cols_bad = 0;

    typedef struct {
        logic [1:0]  r;
        logic [1:0]  c;
        logic        clr;
        logic [3:0]  key;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [6];

    hex_keypad_scanner #(.CNT_WIDTH(2), .DEBOUNCE_TICKS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rows      (rows),
        .i_clear     (i_clear),
        .o_cols      (o_cols),
        .o_key       (o_key),
        .o_key_valid (o_key_valid),
        .o_data      (o_data),
        .o_data_we   (o_data_we)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        if (ka_en && (o_cols[ka_c] == 1'b0)) rows[ka_r] = 1'b0;
        if (kb_en && (o_cols[kb_c] == 1'b0)) rows[kb_r] = 1'b0;
    end

    always @(posedge clk) begin
        if (o_key_valid) valid_cnt <= valid_cnt + 1;
        if (o_data_we)   we_cnt    <= we_cnt + 1;
        if (!rst && !(o_cols inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}))
            cols_bad <= cols_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (o_key_valid) ok = 1'b1;
        end
    endtask

    task automatic sync_to_col(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = o_cols;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (o_cols == target && prev != target) ok = 1'b1;
            prev = o_cols;
        end
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        bit ok;
        ka_r = r;
        ka_c = c;
        ka_en = 1'b1;
        wait_valid(ok);
        check("press_key accepted", 32'(ok), 32'd1);
        repeat (10) @(negedge clk);
        ka_en = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        bit ok;
        int v0;
        int w0;
        logic [3:0] exp_cols;

        rst = 1'b1;
        i_clear = 1'b0;
        vecs[0] = '{2'd1, 2'd2, 1'b0, 4'h6, 16'h0006};
        vecs[1] = '{2'd2, 2'd2, 1'b1, 4'hA, 16'h000A};
        vecs[2] = '{2'd0, 2'd3, 1'b0, 4'h3, 16'h00A3};
        vecs[3] = '{2'd3, 2'd3, 1'b0, 4'hF, 16'h0A3F};
        vecs[4] = '{2'd0, 2'd1, 1'b0, 4'h1, 16'hA3F1};
        vecs[5] = '{2'd1, 2'd1, 1'b0, 4'h5, 16'h3F15};
        repeat (2) @(negedge clk);

        // Reset state and free-running column scan with no keys
        do_reset();
        check("rst o_key", 32'(o_key), 32'h0);
        check("rst o_key_valid", 32'(o_key_valid), 32'h0);
        check("rst o_data", 32'(o_data), 32'h0);
        check("rst o_data_we", 32'(o_data_we), 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_cols = ~(4'b0001 << (k / 4));
            check($sformatf("scan cols k=%0d", k), 32'(o_cols), 32'(exp_cols));
        end
        repeat (16) @(negedge clk);
        check("idle no valid", 32'(valid_cnt), 32'd0);
        check("idle no we", 32'(we_cnt), 32'd0);

        // Bounce: r0c0 stable for 2 ticks only, then released
        do_reset();
        ka_r = 2'd0;
        ka_c = 2'd0;
        ka_en = 1'b1;
        repeat (8) @(negedge clk);
        check("bounce col held k8", 32'(o_cols), 32'h0000000E);
        ka_en = 1'b0;
        repeat (3) @(negedge clk);
        check("bounce col held k11", 32'(o_cols), 32'h0000000E);
        @(negedge clk);
        check("bounce resume col1", 32'(o_cols), 32'h0000000D);
        repeat (40) @(negedge clk);
        check("bounce no valid", 32'(valid_cnt), 32'd0);

        // Table-driven key entry, each key held well past acceptance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) begin
                @(negedge clk);
                i_clear = 1'b1;
                @(negedge clk);
                i_clear = 1'b0;
                check($sformatf("vec%0d clear data", i), 32'(o_data), 32'h0);
                check($sformatf("vec%0d clear we", i), 32'(o_data_we), 32'h1);
                @(negedge clk);
            end
            v0 = valid_cnt;
            w0 = we_cnt;
            ka_r = vecs[i].r;
            ka_c = vecs[i].c;
            ka_en = 1'b1;
            wait_valid(ok);
            check($sformatf("vec%0d accepted", i), 32'(ok), 32'd1);
            if (ok) begin
                check($sformatf("vec%0d o_key", i), 32'(o_key), 32'(vecs[i].key));
                check($sformatf("vec%0d o_data", i), 32'(o_data), 32'(vecs[i].data));
                check($sformatf("vec%0d o_data_we", i), 32'(o_data_we), 32'h1);
            end
            repeat (40) @(negedge clk);
            ka_en = 1'b0;
            repeat (60) @(negedge clk);
            check($sformatf("vec%0d one valid", i), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d one we", i), 32'(we_cnt - w0), 32'd1);
        end

        // Ghosting: r0 and r1 low on col 1 are ignored; r0 alone gives 0x1
        v0 = valid_cnt;
        ka_r = 2'd0; ka_c = 2'd1; ka_en = 1'b1;
        kb_r = 2'd1; kb_c = 2'd1; kb_en = 1'b1;
        repeat (80) @(negedge clk);
        check("ghost ignored", 32'(valid_cnt - v0), 32'd0);
        kb_en = 1'b0;
        wait_valid(ok);
        check("ghost single accepted", 32'(ok), 32'd1);
        check("ghost single o_key", 32'(o_key), 32'h1);
        check("ghost single o_data", 32'(o_data), 32'hF151);
        repeat (10) @(negedge clk);
        ka_en = 1'b0;
        repeat (60) @(negedge clk);

        // Build 0x1234, then clear in the same cycle as accepting 0x7
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        press_key(2'd0, 2'd1);
        press_key(2'd0, 2'd2);
        press_key(2'd0, 2'd3);
        press_key(2'd1, 2'd0);
        check("setup o_data 1234", 32'(o_data), 32'h1234);
        w0 = we_cnt;
        sync_to_col(4'b0111, ok);
        check("sync col3", 32'(ok), 32'd1);
        ka_r = 2'd1; ka_c = 2'd3; ka_en = 1'b1;
        repeat (15) @(negedge clk);
        check("clr+acc no early valid", 32'(o_key_valid), 32'h0);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        check("clr+acc valid", 32'(o_key_valid), 32'h1);
        check("clr+acc o_key", 32'(o_key), 32'h7);
        check("clr+acc o_data", 32'(o_data), 32'h0007);
        check("clr+acc we", 32'(o_data_we), 32'h1);
        @(negedge clk);
        check("clr+acc we drops", 32'(o_data_we), 32'h0);
        check("clr+acc valid drops", 32'(o_key_valid), 32'h0);
        ka_en = 1'b0;
        repeat (60) @(negedge clk);
        check("clr+acc single we", 32'(we_cnt - w0), 32'd1);

        // Reset during debounce of r2c0 discards the key
        v0 = valid_cnt;
        w0 = we_cnt;
        sync_to_col(4'b1110, ok);
        check("sync col0", 32'(ok), 32'd1);
        ka_r = 2'd2; ka_c = 2'd0; ka_en = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        ka_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst o_key", 32'(o_key), 32'h0);
        check("midrst o_data", 32'(o_data), 32'h0);
        check("midrst valid", 32'(o_key_valid), 32'h0);
        check("midrst we", 32'(o_data_we), 32'h0);
        check("midrst cols", 32'(o_cols), 32'h0000000E);
        repeat (60) @(negedge clk);
        check("midrst no valid after", 32'(valid_cnt - v0), 32'd0);
        check("midrst no we after", 32'(we_cnt - w0), 32'd0);

        check("cols always one-hot-low", 32'(cols_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
